dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-port arbiter sharing the single-port 8-bit data memory / MMIO block between port A (CPU load/store) and port B (debug/boot loader).
- Sequences each access as arbitrate -> access -> acknowledge.
- Supports round-robin or fixed priority, and a bounded burst lock for port B.
- Blocks port B from touching the MMIO window.

Parameters:
- ADDR_W, 8, address width
- DATA_W, 8, data width
- MMIO_BASE, 8'hF0, lowest MMIO address; port B accesses at or above it are suppressed
- FIXED_PRIO, 0, 0 = round-robin, 1 = port A always wins ties
- LOCK_MAX, 16, maximum consecutive locked B grants while A is waiting

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- a_req  in  1  port A request; held until a_ack
- a_we  in  1  port A write enable
- a_addr  in  ADDR_W  port A address
- a_wdata  in  DATA_W  port A write data
- a_ack  out  1  one-cycle completion pulse to A
- a_rdata  out  DATA_W  port A read data, valid with a_ack
- b_req  in  1  port B request
- b_we  in  1  port B write enable
- b_lock  in  1  keep grant for the next B access (burst)
- b_addr  in  ADDR_W  port B address
- b_wdata  in  DATA_W  port B write data
- b_ack  out  1  one-cycle completion pulse to B
- b_rdata  out  DATA_W  port B read data, valid with b_ack
- b_err  out  1  with b_ack: access was suppressed (MMIO window)
- mem_addr  out  ADDR_W  address to data memory
- mem_wdata  out  DATA_W  write data to data memory
- mem_we  out  1  write strobe to data memory
- mem_rdata  in  DATA_W  combinational read data from data memory
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: state IDLE; last_owner = B; lock_held = 0; lock_cnt = 0. All outputs are 0.
- Async assert aborts any transaction immediately; mem_we drops with it, no ack is issued, and no write occurs.
- All outputs are registered or decoded from registered state only; none is combinational from the inputs.
- FSM:
  - IDLE: evaluate requests per the grant rules, latch the winner's we/addr/wdata/lock and owner, then go to ACCESS. With no request, stay in IDLE.
  - ACCESS (1 cycle): mem_addr/mem_wdata take the latched values. mem_we = latched we, forced to 0 when the access is suppressed. At the clock edge, capture mem_rdata into the owner's rdata on reads (0 if suppressed); go to ACK.
  - ACK (1 cycle): owner's ack = 1, and b_err = suppressed when the owner is B. Update last_owner, lock_held and lock_cnt; go to IDLE.
- Latency: req seen in IDLE -> ack 2 cycles later; each transaction occupies 3 cycles.
- Grant rules in IDLE, checked in order:
  1. lock_held and b_req -> B, unless a_req and lock_cnt == LOCK_MAX, in which case A wins.
  2. Exactly one requester -> that one.
  3. Both requesting: FIXED_PRIO=1 -> A; otherwise the port that is not last_owner.
- While lock_held and b_req is low, A may be granted; lock_held stays set.
- Lock update in ACK:
  - B access with lock=1 -> lock_held=1; lock_cnt increments (saturating) only while a_req is high.
  - B access with lock=0 -> lock_held=0, lock_cnt=0.
  - A access -> lock_held=0, lock_cnt=0.
- Suppression: owner B and latched addr >= MMIO_BASE. No write is performed; read returns 0. The transaction is still acknowledged, with b_err=1.
- Port A has full address range including MMIO.
- rdata registers change only on a completed read by their own port; writes and other-port accesses leave them unchanged.
- mem_addr/mem_wdata hold their last latched value outside ACCESS. mem_we is 1 only in ACCESS.
- Requester protocol: fields stable from req to ack; req deasserted the cycle after ack or a new request is presented.
  - Dropping req mid-transaction does not cancel it; the latched values complete.
  - A req still high during ACK is treated as a new request in the following IDLE.

Test Plan:
- A write then read: A writes 0x5A to 0x10, then reads 0x10. Required: mem_we high for exactly one cycle at addr 0x10; a_ack 2 cycles after each req; a_rdata = 0x5A.
- Simultaneous requests, FIXED_PRIO=0, from reset: a_req and b_req rise together, both reads. Required: A served first, then B, then A again on the next tie; the acks alternate, 3 cycles apart.
- FIXED_PRIO=1 tie: A requests continuously and B is pending. Required: B is never granted while a_req is held high.
- B MMIO guard: B writes 0x33 to 0xF3, then reads 0xF0. Required: mem_we stays 0; b_ack with b_err=1 both times; b_rdata = 0x00. An A write to 0xF3 produces mem_we=1.
- Burst lock and ceiling, LOCK_MAX=4: B issues 8 locked reads to 0x00–0x07 while A holds a read request. Required: A is granted after the 4th locked B ack; B then resumes. A B access with lock=0 clears the lock.
- Reset mid-op: assert rst_n low during ACCESS of an A write to 0x20. Required: mem_we goes 0 asynchronously; no a_ack; memory at 0x20 unchanged; busy=0; next tie grants A.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the shared single-port data memory / MMIO block.
// Each access runs IDLE -> ACCESS -> ACK; port B is fenced off from the MMIO window.
module dmem_arbiter #(
    parameter int                ADDR_W     = 8,
    parameter int                DATA_W     = 8,
    parameter logic [ADDR_W-1:0] MMIO_BASE  = 8'hF0,
    parameter bit                FIXED_PRIO = 1'b0,
    parameter int                LOCK_MAX   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic              b_lock,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] ACK    = 2'd2;

    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

    localparam int              CNT_W   = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

    logic [1:0]       state;
    logic             owner;
    logic             last_owner;
    logic             lat_we;
    logic             lat_lock;
    logic             supp;
    logic             lock_held;
    logic [CNT_W-1:0] lock_cnt;

    logic grant_any;
    logic grant_b;

    // Lock keeps B only until A has waited out LOCK_MAX locked B grants.
    always_comb begin
        grant_any = a_req | b_req;
        grant_b   = 1'b0;
        if (lock_held && b_req)
            grant_b = !(a_req && lock_cnt == CNT_MAX);
        else if (a_req ^ b_req)
            grant_b = b_req;
        else if (a_req && b_req)
            grant_b = FIXED_PRIO ? 1'b0 : (last_owner == OWN_A);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= OWN_A;
            last_owner <= OWN_B;
            lat_we     <= 1'b0;
            lat_lock   <= 1'b0;
            supp       <= 1'b0;
            lock_held  <= 1'b0;
            lock_cnt   <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            a_rdata    <= '0;
            b_rdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        owner     <= grant_b ? OWN_B : OWN_A;
                        lat_we    <= grant_b ? b_we : a_we;
                        mem_addr  <= grant_b ? b_addr : a_addr;
                        mem_wdata <= grant_b ? b_wdata : a_wdata;
                        lat_lock  <= grant_b & b_lock;
                        supp      <= grant_b && (b_addr >= MMIO_BASE);
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!lat_we) begin
                        if (owner == OWN_B)
                            b_rdata <= supp ? '0 : mem_rdata;
                        else
                            a_rdata <= mem_rdata;
                    end
                    state <= ACK;
                end
                ACK: begin
                    last_owner <= owner;
                    if (owner == OWN_B && lat_lock) begin
                        lock_held <= 1'b1;
                        if (a_req && lock_cnt != CNT_MAX)
                            lock_cnt <= lock_cnt + 1'b1;
                    end else begin
                        lock_held <= 1'b0;
                        lock_cnt  <= '0;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // All outputs decode registered state, so reset drops mem_we asynchronously.
    assign mem_we = (state == ACCESS) && lat_we && !supp;
    assign a_ack  = (state == ACK) && (owner == OWN_A);
    assign b_ack  = (state == ACK) && (owner == OWN_B);
    assign b_err  = (state == ACK) && (owner == OWN_B) && supp;
    assign busy   = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: round-robin/lock instance plus a fixed-priority instance.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Round-robin instance with a short lock ceiling.
    logic       a_req = 0, a_we = 0, b_req = 0, b_we = 0, b_lock = 0;
    logic [7:0] a_addr = 0, a_wdata = 0, b_addr = 0, b_wdata = 0;
    logic       a_ack, b_ack, b_err, mem_we, busy;
    logic [7:0] a_rdata, b_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [7:0] mem [256];

    dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .MMIO_BASE(8'hF0), .FIXED_PRIO(1'b0), .LOCK_MAX(4)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata), .busy(busy)
    );

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    // Fixed-priority instance; memory returns zero.
    logic       fa_req = 0, fb_req = 0;
    logic [7:0] f_zero = 8'h00;
    logic       fa_ack, fb_ack, fb_err, fmem_we, fbusy;
    logic [7:0] fa_rdata, fb_rdata, fmem_addr, fmem_wdata;

    dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .MMIO_BASE(8'hF0), .FIXED_PRIO(1'b1), .LOCK_MAX(16)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .a_req(fa_req), .a_we(1'b0), .a_addr(8'h01), .a_wdata(f_zero), .a_ack(fa_ack), .a_rdata(fa_rdata),
        .b_req(fb_req), .b_we(1'b0), .b_lock(1'b0), .b_addr(8'h02), .b_wdata(f_zero),
        .b_ack(fb_ack), .b_rdata(fb_rdata), .b_err(fb_err),
        .mem_addr(fmem_addr), .mem_wdata(fmem_wdata), .mem_we(fmem_we), .mem_rdata(f_zero), .busy(fbusy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int fa_acks;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        mem[8'h40] <= 8'h11;
        mem[8'h41] <= 8'h22;
        mem[8'hF0] <= 8'hAB;
        mem[8'hF3] <= 8'h99;
        mem[8'h20] <= 8'h77;
        for (int i = 0; i < 8; i++) mem[i] <= 8'h80 + 8'(i);

        // Reset state
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_acks", {a_ack, b_ack, b_err}, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_rdata", {a_rdata, b_rdata}, 0);
        rst_n = 1'b1;
        tick();

        // Tie from reset: A, then B, then A, 3 cycles apart
        a_req = 1; a_addr = 8'h40; b_req = 1; b_addr = 8'h41;
        tick();
        chk("tie1_addr", mem_addr, 8'h40);
        tick();
        chk("tie1_ack", {a_ack, b_ack}, 2'b10);
        chk("tie1_rdata", a_rdata, 8'h11);
        tick();
        chk("tie1_idle", busy, 0);
        tick();
        chk("tie2_addr", mem_addr, 8'h41);
        tick();
        chk("tie2_ack", {a_ack, b_ack, b_err}, 3'b010);
        chk("tie2_rdata", b_rdata, 8'h22);
        tick();
        tick();
        chk("tie3_addr", mem_addr, 8'h40);
        tick();
        chk("tie3_ack", {a_ack, b_ack}, 2'b10);
        a_req = 0; b_req = 0;
        tick();

        // A write 0x5A to 0x10, then read it back
        a_req = 1; a_we = 1; a_addr = 8'h10; a_wdata = 8'h5A;
        tick();
        chk("aw_access", {busy, mem_we, a_ack}, 3'b110);
        chk("aw_addr", {mem_addr, mem_wdata}, 16'h105A);
        tick();
        chk("aw_ack", {a_ack, mem_we}, 2'b10);
        chk("aw_mem", mem[8'h10], 8'h5A);
        a_req = 0; a_we = 0;
        tick();
        chk("aw_idle", {busy, mem_we, a_ack}, 0);
        a_req = 1;
        tick();
        chk("ar_we", mem_we, 0);
        tick();
        chk("ar_ack", a_ack, 1);
        chk("ar_rdata", a_rdata, 8'h5A);
        a_req = 0;
        tick();

        // B into the MMIO window is suppressed
        b_req = 1; b_we = 1; b_addr = 8'hF3; b_wdata = 8'h33;
        tick();
        chk("bw_mmio_we", {busy, mem_we}, 2'b10);
        tick();
        chk("bw_mmio_ack", {b_ack, b_err}, 2'b11);
        b_req = 0; b_we = 0;
        tick();
        chk("bw_mmio_mem", mem[8'hF3], 8'h99);
        b_req = 1; b_addr = 8'hF0;
        tick();
        tick();
        chk("br_mmio_ack", {b_ack, b_err}, 2'b11);
        chk("br_mmio_rdata", b_rdata, 8'h00);
        b_req = 0;
        tick();
        a_req = 1; a_we = 1; a_addr = 8'hF3; a_wdata = 8'h44;
        tick();
        chk("aw_mmio_we", mem_we, 1);
        tick();
        chk("aw_mmio_ack", {a_ack, b_err}, 2'b10);
        a_req = 0; a_we = 0;
        tick();
        chk("aw_mmio_mem", mem[8'hF3], 8'h44);

        // Burst lock: A waits out 4 locked B grants
        b_req = 1; b_lock = 1; b_addr = 8'h00;
        tick();
        chk("lk0_addr", mem_addr, 8'h00);
        a_req = 1; a_addr = 8'h10;
        tick();
        chk("lk0_ack", {a_ack, b_ack, b_rdata}, {2'b01, 8'h80});
        for (int i = 1; i < 4; i++) begin
            b_addr = 8'(i);
            tick();
            tick();
            chk("lk_addr", mem_addr, i);
            tick();
            chk("lk_ack", {a_ack, b_ack, b_rdata}, {2'b01, 8'h80 + 8'(i)});
        end
        b_addr = 8'h04;
        tick();
        tick();
        chk("lk_ceiling_a", mem_addr, 8'h10);
        tick();
        chk("lk_ceiling_ack", {a_ack, b_ack, a_rdata}, {2'b10, 8'h5A});
        a_req = 0;
        for (int i = 4; i < 8; i++) begin
            b_addr = 8'(i);
            if (i == 7) b_lock = 0;
            tick();
            tick();
            chk("lk_resume_addr", mem_addr, i);
            tick();
            chk("lk_resume_ack", {b_ack, b_rdata}, {1'b1, 8'h80 + 8'(i)});
        end
        // Lock released by the unlocked access: the tie goes to A
        a_req = 1; a_addr = 8'h10; b_addr = 8'h00;
        tick();
        tick();
        chk("unlock_tie", mem_addr, 8'h10);
        tick();
        chk("unlock_ack", {a_ack, b_ack}, 2'b10);
        a_req = 0;
        tick();
        tick();
        tick();
        chk("unlock_b", b_ack, 1);
        b_req = 0;
        tick();

        // Reset during ACCESS of an A write
        a_req = 1; a_we = 1; a_addr = 8'h20; a_wdata = 8'hEE;
        tick();
        chk("rm_access", mem_we, 1);
        #2 rst_n = 0;
        #1;
        chk("rm_we_drop", {mem_we, busy, a_ack}, 0);
        tick();
        chk("rm_no_ack", a_ack, 0);
        a_req = 0; a_we = 0;
        tick();
        chk("rm_mem", mem[8'h20], 8'h77);
        rst_n = 1;
        a_req = 1; a_addr = 8'h10; b_req = 1; b_addr = 8'h41;
        tick();
        chk("rm_tie_addr", mem_addr, 8'h10);
        tick();
        chk("rm_tie_ack", {a_ack, b_ack}, 2'b10);
        a_req = 0; b_req = 0;
        tick();

        // Fixed priority: B starves while A stays high
        fa_req = 1; fb_req = 1; fa_acks = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("fp_no_b", fb_ack, 0);
            if (fa_ack) fa_acks++;
        end
        chk("fp_a_acks", fa_acks, 4);
        fa_req = 0;
        tick();
        tick();
        chk("fp_b_after", {fa_ack, fb_ack}, 2'b01);
        fb_req = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
